l2_miss_refill_ctrl: RTL

// - L2-side initiator of the L2<->MEM line protocol; peer of the DDR2 line bridge (read_L2_MEM/write_L2_MEM/ready_MEM_L2).
// - Accepts one L2 miss at a time, issues the dirty-victim writeback if needed, then the refill read.
// - Returns the 512-bit line to L2 as a one-cycle fill pulse. Sits between the L2 controller and the bridge.

---
 rtl/l2_miss_refill_ctrl_pkg.sv | 21 ++
 rtl/l2_miss_refill_ctrl_sat_counter.sv | 25 ++
 rtl/l2_miss_refill_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/l2_miss_refill_ctrl_pkg.sv
// Shared widths and FSM state encoding for the L2 miss refill controller.
// The helper identifies the two states that legitimately wait on ready_MEM_L2.
package l2_miss_refill_ctrl_pkg;

  localparam int LINE_W = 512;
  localparam int TAG_W  = 18;
  localparam int IDX_W  = 8;
  localparam int WTAG_W = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WB_REQ  = 3'd1;
  localparam logic [2:0] ST_WB_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_FILL    = 3'd5;

  function automatic logic is_wait(input logic [2:0] st);
    return (st == ST_WB_WAIT) || (st == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/l2_miss_refill_ctrl_sat_counter.sv
// Event counter that increments on inc_i and sticks at all-ones.
module l2_miss_refill_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_cpu,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/l2_miss_refill_ctrl.sv
// L2-side initiator of the L2<->MEM line protocol: optional dirty-victim
// writeback, then refill read, then a one-cycle fill pulse back to L2.
//
// state    | meaning
// IDLE     | ready for a miss
// WB_REQ   | write pulse to bridge
// WB_WAIT  | waiting for writeback completion
// RD_REQ   | read pulse to bridge
// RD_WAIT  | waiting for refill data
// FILL     | fill pulse to L2
module l2_miss_refill_ctrl
  import l2_miss_refill_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              clk_cpu,
  input  logic              rst_n,
  input  logic              miss_req,
  output logic              miss_ready,
  input  logic [TAG_W-1:0]  miss_tag,
  input  logic [IDX_W-1:0]  miss_index,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [LINE_W-1:0] victim_data,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [IDX_W-1:0]  fill_index,
  output logic              read_L2_MEM,
  output logic              write_L2_MEM,
  output logic [TAG_W-1:0]  tag_L2_MEM,
  output logic [IDX_W-1:0]  index_L2_MEM,
  output logic [WTAG_W-1:0] write_tag_L2_MEM,
  output logic [LINE_W-1:0] write_data_L2_MEM,
  input  logic [LINE_W-1:0] read_data_MEM_L2,
  input  logic              ready_MEM_L2,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic              err_timeout,
  output logic              err_protocol
);

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  logic [2:0]        state_q, state_d;
  logic              miss_ready_q, miss_ready_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              fill_q, fill_d;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WTAG_W-1:0] vtag_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] fdata_q;
  logic [31:0]       wait_q;
  logic              err_to_q, err_pr_q;
  logic              accept;
  logic              unused_vtag_hi;

  // The bridge only consumes the low 16 bits of the victim tag.
  assign unused_vtag_hi = ^victim_tag[TAG_W-1:WTAG_W];

  assign accept = (state_q == ST_IDLE) && miss_ready_q && miss_req;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      miss_ready_q <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      fill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_ready_q <= miss_ready_d;
      write_q      <= write_d;
      read_q       <= read_d;
      fill_q       <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = victim_dirty ? ST_WB_REQ : ST_RD_REQ;
      ST_WB_REQ:  state_d = ST_WB_WAIT;
      ST_WB_WAIT: if (ready_MEM_L2) state_d = ST_RD_REQ;
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (ready_MEM_L2) state_d = ST_FILL;
      ST_FILL:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so request pulses never glitch.
  always_comb begin
    miss_ready_d = (state_d == ST_IDLE);
    write_d      = (state_d == ST_WB_REQ);
    read_d       = (state_d == ST_RD_REQ);
    fill_d       = (state_d == ST_FILL);
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      idx_q    <= '0;
      vtag_q   <= '0;
      wdata_q  <= '0;
      fdata_q  <= '0;
      wait_q   <= '0;
      err_to_q <= 1'b0;
      err_pr_q <= 1'b0;
    end else begin
      if (accept) begin
        tag_q   <= miss_tag;
        idx_q   <= miss_index;
        vtag_q  <= victim_tag[WTAG_W-1:0];
        wdata_q <= victim_data;
      end
      if ((state_q == ST_RD_WAIT) && ready_MEM_L2) fdata_q <= read_data_MEM_L2;
      if (!is_wait(state_q))     wait_q <= '0;
      else if (wait_q != TO_LIM) wait_q <= wait_q + 32'd1;
      if ((TIMEOUT_CYCLES != 0) && is_wait(state_q) && (wait_q == TO_LIM)) err_to_q <= 1'b1;
      if (ready_MEM_L2 && !is_wait(state_q)) err_pr_q <= 1'b1;
    end
  end

  l2_miss_refill_ctrl_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .inc_i   (state_q == ST_FILL),
    .cnt_o   (miss_cnt)
  );

  l2_miss_refill_ctrl_sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .inc_i   ((state_q == ST_WB_WAIT) && ready_MEM_L2),
    .cnt_o   (wb_cnt)
  );

  assign miss_ready        = miss_ready_q;
  assign write_L2_MEM      = write_q;
  assign read_L2_MEM       = read_q;
  assign fill_valid        = fill_q;
  assign fill_data         = fdata_q;
  assign fill_tag          = tag_q;
  assign fill_index        = idx_q;
  assign tag_L2_MEM        = tag_q;
  assign index_L2_MEM      = idx_q;
  assign write_tag_L2_MEM  = vtag_q;
  assign write_data_L2_MEM = wdata_q;
  assign err_timeout       = err_to_q;
  assign err_protocol      = err_pr_q;

endmodule
